io_po_bank: RTL
===============

# io_po_bank

Parametrised FPGA-to-SoC output bank, the successor to the single-bit `poutput` pad tile. It carries a WIDTH-bit word from the fabric output pins to the SoC boundary. The mode is selected at runtime: combinational bypass, a single pipeline register, or a DEPTH-entry show-ahead FIFO with valid/ready handshake on both sides. It also keeps a sticky overflow flag and reports FIFO occupancy. It sits inside the io_po logical tile, between the fabric outpad nets and the `gfpga_pad_poutput_F2A` SoC pins.

## Interface
- `WIDTH`, default 8: data word width, ≥1.
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `LW`, default $clog2(DEPTH)+1: width of `level_o`. Derived; do not override.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `cfg_mode`  in  2: operating mode. 00 bypass, 01 registered, 10 fifo, 11 hold.
- `io_po_core_outpad`  in  WIDTH: fabric data word.
- `io_po_core_valid`  in  1: fabric word valid.
- `io_po_core_ready`  out  1: bank can accept a word.
- `gfpga_pad_poutput_F2A`  out  WIDTH: data to the SoC.
- `soc_valid_o`  out  1: SoC-side data valid.
- `soc_ready_i`  in  1: SoC accepts the word.
- `overflow_o`  out  1: sticky flag, set when a word is lost.
- `ovf_clr_i`  in  1: clears `overflow_o`.
- `level_o`  out  LW: FIFO occupancy, range 0..DEPTH.

## Operation
- **Reset** (`rst_n`=0 at a clock edge):
  - Output register, FIFO pointers, level, overflow and the previous-mode register all clear.
  - Register-driven outputs then read 0: `gfpga_pad_poutput_F2A`, `soc_valid_o`, `overflow_o`, `level_o`.
  - `io_po_core_ready` reads 0 unless mode is 00 or 10.
- **Bypass (00)**: purely combinational and unaffected by `rst_n`.
  - `gfpga_pad_poutput_F2A` = `io_po_core_outpad`.
  - `soc_valid_o` = `io_po_core_valid`.
  - `io_po_core_ready` = `soc_ready_i`.
  - FIFO is held empty. `level_o` = 0.
- **Registered (01)**: one-stage pipeline with no backpressure.
  - `io_po_core_ready` = 1.
  - Every cycle the output register loads `io_po_core_outpad` and `soc_valid_o` loads `io_po_core_valid`.
  - Overflow sets if `soc_valid_o`=1, `soc_ready_i`=0 and `io_po_core_valid`=1 in the same cycle, because the unaccepted word is overwritten.
- **FIFO (10)**: show-ahead FIFO.
  - `io_po_core_ready` = !full.
  - Push when valid && ready. Pop when `soc_valid_o` && `soc_ready_i`.
  - `soc_valid_o` = !empty. `gfpga_pad_poutput_F2A` = head entry; it holds its value while not popped.
  - Full (level = DEPTH): no push, even if a pop happens in the same cycle.
  - Overflow sets if `io_po_core_valid`=1 while full. The word is dropped.
  - Empty with a push: the word becomes visible on the next cycle.
  - Push and pop in the same non-full, non-empty cycle: level is unchanged.
  - Read and write pointers wrap modulo DEPTH.
- **Hold (11)**:
  - Output register and FIFO contents are frozen.
  - `soc_valid_o` = 0, `io_po_core_ready` = 0, `level_o` holds its value.
- **Mode change**: when `cfg_mode` differs from its registered previous value, on that edge:
  - FIFO flushes to level 0.
  - Output register clears to 0.
  - The new mode's behaviour applies from the following cycle.
  - `overflow_o` is unaffected.
- **Overflow clear**: `ovf_clr_i`=1 clears `overflow_o` on the next edge. A set condition in the same cycle wins.

## Timing
- Latency from fabric input to SoC output:
  - Bypass: 0 cycles.
  - Registered: 1 cycle.
  - FIFO: 1 cycle minimum, from push edge to visible head.
- FIFO throughput: 1 word/cycle sustained while 0 < level < DEPTH.
- `level_o` and `overflow_o` are registered and update on the same edge as the push, pop or set that changes them.
- `io_po_core_ready` in FIFO mode is derived from registered state only; there is no combinational path from `soc_ready_i`.
- Reset takes priority over mode-change flush and over every push/pop.

## Test plan
- **Reset, then mode 10, no input**: `soc_valid_o`=0, `level_o`=0, `io_po_core_ready`=1, `overflow_o`=0.
- **FIFO mode, DEPTH=4**:
  - Push 0x11, 0x22, 0x33, 0x44 with `soc_ready_i`=0 → `level_o`=4, `io_po_core_ready`=0, F2A=0x11.
  - Then a 5th valid word 0x55 → `overflow_o`=1, `level_o` stays 4.
  - Then `soc_ready_i`=1 for 4 cycles → SoC receives 0x11, 0x22, 0x33, 0x44 in order, ending at level 0.
- **FIFO, simultaneous push and pop at level 2 for 8 cycles** → level stays 2, data stays in order, and the pointers wrap correctly.
- **Registered mode**: drive 0xA5 with valid=1 → F2A=0xA5 one cycle later. With `soc_ready_i`=0 and a new valid word arriving → `overflow_o`=1. Then `ovf_clr_i`=1 with no new set → `overflow_o`=0 on the next edge.
- **Bypass mode**: toggle outpad 0x3C→0xC3 → F2A follows in the same cycle. `io_po_core_ready` mirrors `soc_ready_i`, including while `rst_n`=0.
- **Mode change from 10 at level 3 to 11, then to 10**: flush on each change → `level_o`=0, F2A=0, `soc_valid_o`=0. Pulsing `rst_n` low mid-FIFO → everything cleared after one edge.

Source files
------------

// File: rtl/io_po_bank.sv
`default_nettype none
// ============================================================================
//  Module   : io_po_bank
//  Purpose  : Fabric-to-SoC output bank: bypass, one-stage register or
//             show-ahead FIFO, with sticky overflow flag and occupancy.
//  Revision : 1.0  initial release
// ============================================================================
module io_po_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] io_po_core_outpad,
    input  logic             io_po_core_valid,
    output logic             io_po_core_ready,
    output logic [WIDTH-1:0] gfpga_pad_poutput_F2A,
    output logic             soc_valid_o,
    input  logic             soc_ready_i,
    output logic             overflow_o,
    input  logic             ovf_clr_i,
    output logic [LW-1:0]    level_o
);

    localparam int            c_AW        = $clog2(DEPTH);
    localparam logic [1:0]    c_MODE_BYP  = 2'b00;
    localparam logic [1:0]    c_MODE_REG  = 2'b01;
    localparam logic [1:0]    c_MODE_FIFO = 2'b10;
    localparam logic [LW-1:0] c_FULL_LVL  = LW'(DEPTH);

    logic [1:0]       r_prev_mode;
    logic [WIDTH-1:0] r_out_reg;
    logic             r_out_vld;
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_ovf;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_mode_chg;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic [LW-1:0]    w_lvl_nxt;

    assign w_mode_chg = (cfg_mode != r_prev_mode);
    assign w_full     = (r_level == c_FULL_LVL);
    assign w_empty    = (r_level == '0);

    // On a mode-change edge the bank only flushes; the new mode acts next cycle.
    assign w_push = (cfg_mode == c_MODE_FIFO) && !w_mode_chg && io_po_core_valid && !w_full;
    assign w_pop  = (cfg_mode == c_MODE_FIFO) && !w_mode_chg && !w_empty && soc_ready_i;

    assign w_ovf_set = !w_mode_chg &&
                       (((cfg_mode == c_MODE_REG) && r_out_vld && !soc_ready_i && io_po_core_valid) ||
                        ((cfg_mode == c_MODE_FIFO) && w_full && io_po_core_valid));

    assign w_lvl_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_mode <= 2'b00;
            r_out_reg   <= '0;
            r_out_vld   <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_prev_mode <= cfg_mode;

            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr_i) begin
                r_ovf <= 1'b0;
            end

            if (w_mode_chg) begin
                r_out_reg <= '0;
                r_out_vld <= 1'b0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_level   <= '0;
            end else if (cfg_mode == c_MODE_REG) begin
                r_out_reg <= io_po_core_outpad;
                r_out_vld <= io_po_core_valid;
            end else if (cfg_mode == c_MODE_FIFO) begin
                // Pointers are c_AW bits wide, so they wrap modulo DEPTH for free.
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_level <= w_lvl_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= io_po_core_outpad;
        end
    end

    always_comb begin
        gfpga_pad_poutput_F2A = r_out_reg;
        soc_valid_o           = 1'b0;
        io_po_core_ready      = 1'b0;
        level_o               = r_level;
        case (cfg_mode)
            c_MODE_BYP: begin
                gfpga_pad_poutput_F2A = io_po_core_outpad;
                soc_valid_o           = io_po_core_valid;
                io_po_core_ready      = soc_ready_i;
                level_o               = '0;
            end
            c_MODE_REG: begin
                gfpga_pad_poutput_F2A = r_out_reg;
                soc_valid_o           = r_out_vld;
                io_po_core_ready      = rst_n;
            end
            c_MODE_FIFO: begin
                // An empty FIFO presents zero rather than stale storage.
                gfpga_pad_poutput_F2A = w_empty ? '0 : r_mem[r_rd_ptr];
                soc_valid_o           = !w_empty;
                io_po_core_ready      = !w_full;
            end
            default: begin
                gfpga_pad_poutput_F2A = r_out_reg;
                soc_valid_o           = 1'b0;
                io_po_core_ready      = 1'b0;
            end
        endcase
    end

    assign overflow_o = r_ovf;

endmodule
`default_nettype wire
